// File: rtl/rvv_cmd_dispatch.sv
// rvv_cmd_dispatch: in-order fifo head dispatcher to credit-flow-controlled backend units with barrier drain
module rvv_cmd_dispatch #(
  parameter int N = 4,
  parameter int CMD_BUFFER_MAX_CAPACITY = 16,
  parameter int NUM_UNITS = 3,
  parameter int CREDITS = 4,
  parameter int CMD_W = 32,
  localparam int UNIT_W = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int FW = $clog2(CMD_BUFFER_MAX_CAPACITY + 1),
  localparam int PW = $clog2(N + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [FW-1:0]                       fill_level_i,
  input  logic [N-1:0][CMD_W-1:0]             cmd_data_i,
  input  logic [N-1:0][UNIT_W-1:0]            cmd_unit_i,
  input  logic [N-1:0]                        cmd_barrier_i,
  output logic [PW-1:0]                       pop_count_o,
  output logic [NUM_UNITS-1:0]                issue_valid_o,
  output logic [NUM_UNITS-1:0][CMD_W-1:0]     issue_data_o,
  input  logic [NUM_UNITS-1:0]                credit_return_i,
  output logic                                draining_o,
  output logic                                credit_err_o
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] credit [NUM_UNITS];
  logic all_full;
  logic [NUM_UNITS-1:0] sel;
  logic [NUM_UNITS-1:0][CMD_W-1:0] sel_data;
  logic [PW-1:0] pop;
  logic stop, bar, ok;
  always_comb begin
    all_full = 1'b1;
    for (int u = 0; u < NUM_UNITS; u++) all_full = all_full && credit[u] == CW'(CREDITS);
  end
  always_comb begin
    sel = '0;
    sel_data = issue_data_o;
    pop = '0;
    stop = 1'b0;
    bar = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      ok = !stop && !bar && state == RUN && i < int'(fill_level_i) && int'(cmd_unit_i[i]) < NUM_UNITS;
      if (ok) ok = !sel[cmd_unit_i[i]] && credit[cmd_unit_i[i]] != '0 && !(cmd_barrier_i[i] && (i != 0 || !all_full));
      if (ok) begin
        sel[cmd_unit_i[i]] = 1'b1;
        sel_data[cmd_unit_i[i]] = cmd_data_i[i];
        pop = pop + PW'(1);
        bar = cmd_barrier_i[i];
      end else stop = 1'b1;
    end
  end
  always_comb begin
    state_nx = state == RUN ? ((fill_level_i != '0 && cmd_barrier_i[0] && !all_full) ? DRAIN : RUN)
                            : (all_full ? RUN : DRAIN);
    pop_count_o = pop;
    draining_o = state == DRAIN;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      issue_valid_o <= '0;
      issue_data_o <= '0;
      credit_err_o <= 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) credit[u] <= CW'(CREDITS);
    end else begin
      state <= state_nx;
      issue_valid_o <= sel;
      issue_data_o <= sel_data;
      for (int u = 0; u < NUM_UNITS; u++)
        if (credit_return_i[u] && !sel[u] && credit[u] == CW'(CREDITS)) credit_err_o <= 1'b1;
        else credit[u] <= credit[u] - CW'(sel[u]) + CW'(credit_return_i[u]);
    end
  end
endmodule

// File: tb/tb_rvv_cmd_dispatch.sv
// tb_rvv_cmd_dispatch: scoreboard bench driving a modelled fifo head into rvv_cmd_dispatch
module tb_rvv_cmd_dispatch;
  localparam int N = 4, NU = 3, FW = 5, PW = 3, UW = 2;
  typedef struct packed {
    logic [NU-1:0] v;
    logic [NU-1:0][31:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rstn;
  logic [FW-1:0] fill_level_i;
  logic [N-1:0][31:0] cmd_data_i;
  logic [N-1:0][UW-1:0] cmd_unit_i;
  logic [N-1:0] cmd_barrier_i;
  logic [PW-1:0] pop_count_o;
  logic [NU-1:0] issue_valid_o;
  logic [NU-1:0][31:0] issue_data_o;
  logic [NU-1:0] credit_return_i;
  logic draining_o, credit_err_o;
  int total = 0, bad = 0, fill_ovr = -1;
  logic [31:0] fq_d[$];
  int fq_u[$];
  logic fq_b[$];
  exp_t sb[$];
  logic [NU-1:0][31:0] last_d;
  rvv_cmd_dispatch dut (
    .clk(clk), .rstn(rstn), .fill_level_i(fill_level_i), .cmd_data_i(cmd_data_i),
    .cmd_unit_i(cmd_unit_i), .cmd_barrier_i(cmd_barrier_i), .pop_count_o(pop_count_o),
    .issue_valid_o(issue_valid_o), .issue_data_o(issue_data_o), .credit_return_i(credit_return_i),
    .draining_o(draining_o), .credit_err_o(credit_err_o)
  );
  always #5 clk = ~clk;
  task automatic push(input logic [31:0] d, input int u, input logic b);
    fq_d.push_back(d);
    fq_u.push_back(u);
    fq_b.push_back(b);
  endtask
  task automatic cycle(input int exp_pop, input logic [NU-1:0] ret);
    exp_t e;
    int n, got;
    credit_return_i = ret;
    n = fq_d.size();
    fill_level_i = fill_ovr >= 0 ? FW'(fill_ovr) : FW'(n > 16 ? 16 : n);
    for (int i = 0; i < N; i++) begin
      cmd_data_i[i] = i < n ? fq_d[i] : 32'h0;
      cmd_unit_i[i] = i < n ? UW'(fq_u[i]) : '0;
      cmd_barrier_i[i] = i < n ? fq_b[i] : 1'b0;
    end
    #3;
    total++;
    if (pop_count_o !== PW'(exp_pop)) begin
      bad++;
      $display("FAIL pop_count t=%0t: got %0d want %0d", $time, pop_count_o, exp_pop);
    end
    e.v = '0;
    e.d = last_d;
    for (int i = 0; i < exp_pop && i < n; i++) begin
      e.v[fq_u[i]] = 1'b1;
      e.d[fq_u[i]] = fq_d[i];
    end
    sb.push_back(e);
    last_d = e.d;
    got = int'(pop_count_o);
    for (int i = 0; i < got && fq_d.size() > 0; i++) begin
      void'(fq_d.pop_front());
      void'(fq_u.pop_front());
      void'(fq_b.pop_front());
    end
    @(posedge clk);
    #1;
    credit_return_i = '0;
    e = sb.pop_front();
    total++;
    if (issue_valid_o !== e.v) begin
      bad++;
      $display("FAIL issue_valid t=%0t: got %b want %b", $time, issue_valid_o, e.v);
    end
    total++;
    if (issue_data_o !== e.d) begin
      bad++;
      $display("FAIL issue_data t=%0t: got %h want %h", $time, issue_data_o, e.d);
    end
  endtask
  task automatic chk(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t: got %b want %b", name, $time, got, want);
    end
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    fill_level_i = '0;
    cmd_data_i = '0;
    cmd_unit_i = '0;
    cmd_barrier_i = '0;
    credit_return_i = '0;
    last_d = '0;
    @(posedge clk);
    #1;
    total++;
    if (issue_valid_o !== '0 || issue_data_o !== '0 || pop_count_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h pop=%0d want 0", issue_valid_o, issue_data_o, pop_count_o);
    end
    chk("reset_draining", draining_o, 1'b0);
    chk("reset_err", credit_err_o, 1'b0);
    rstn = 1'b1;
  endtask
  task automatic test_parallel;
    push(32'h101, 0, 0); push(32'h102, 1, 0); push(32'h103, 2, 0); push(32'h104, 0, 0);
    cycle(3, '0);
    cycle(1, '0);
    cycle(0, 3'b001);
    cycle(0, 3'b111);
    chk("parallel_err", credit_err_o, 1'b0);
  endtask
  task automatic test_hammer;
    for (int k = 0; k < 5; k++) push(32'h200 + k, 1, 0);
    for (int k = 0; k < 4; k++) cycle(1, '0);
    cycle(0, '0);
    cycle(0, 3'b010);
    cycle(1, '0);
    for (int k = 0; k < 4; k++) cycle(0, 3'b010);
    chk("hammer_err", credit_err_o, 1'b0);
  endtask
  task automatic test_barrier;
    push(32'h301, 0, 0); push(32'h302, 1, 0); push(32'h303, 2, 1); push(32'h304, 0, 0);
    cycle(2, '0);
    chk("pre_drain", draining_o, 1'b0);
    cycle(0, '0);
    chk("drain_enter", draining_o, 1'b1);
    cycle(0, 3'b011);
    chk("drain_hold", draining_o, 1'b1);
    cycle(0, '0);
    chk("drain_exit", draining_o, 1'b0);
    cycle(1, '0);
    cycle(1, '0);
    cycle(0, 3'b101);
    chk("barrier_err", credit_err_o, 1'b0);
  endtask
  task automatic test_credit_net;
    push(32'h401, 0, 0); push(32'h402, 0, 0);
    cycle(1, '0);
    cycle(1, '0);
    push(32'h403, 0, 0);
    cycle(1, 3'b001);
    push(32'h404, 0, 0); push(32'h405, 0, 0); push(32'h406, 0, 0);
    cycle(1, '0);
    cycle(1, '0);
    cycle(0, '0);
    cycle(0, 3'b001);
    cycle(1, '0);
    for (int k = 0; k < 4; k++) cycle(0, 3'b001);
    chk("err_clear", credit_err_o, 1'b0);
    cycle(0, 3'b010);
    chk("err_set", credit_err_o, 1'b1);
    cycle(0, '0);
    chk("err_sticky", credit_err_o, 1'b1);
  endtask
  task automatic test_fill_limit;
    push(32'h501, 0, 0); push(32'h502, 1, 0); push(32'h503, 2, 0); push(32'h504, 0, 0);
    fill_ovr = 1;
    cycle(1, '0);
    fill_ovr = 0;
    cycle(0, '0);
    fill_ovr = -1;
    cycle(3, '0);
    cycle(0, 3'b111);
    cycle(0, 3'b001);
  endtask
  task automatic test_reset_mid_drain;
    push(32'h601, 0, 0); push(32'h602, 0, 0); push(32'h603, 0, 0); push(32'h604, 1, 1);
    for (int k = 0; k < 3; k++) cycle(1, '0);
    cycle(0, '0);
    chk("mid_drain", draining_o, 1'b1);
    rstn = 1'b0;
    fq_d.delete();
    fq_u.delete();
    fq_b.delete();
    fill_level_i = '0;
    last_d = '0;
    #1;
    total++;
    if (issue_valid_o !== '0 || issue_data_o !== '0 || pop_count_o !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: got v=%b d=%h pop=%0d want 0", issue_valid_o, issue_data_o, pop_count_o);
    end
    chk("midreset_draining", draining_o, 1'b0);
    chk("midreset_err", credit_err_o, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push(32'h701, 0, 1);
    for (int k = 0; k < 4; k++) push(32'h710 + k, 2, 0);
    cycle(1, '0);
    for (int k = 0; k < 4; k++) cycle(1, '0);
  endtask
  initial begin
    test_reset();
    test_parallel();
    test_hammer();
    test_barrier();
    test_credit_net();
    test_fill_limit();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
